ex_muldiv_unit: RTL and testbench

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/ex_muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// RV32M execute unit: 1-cycle multiply (done at N+2), 32-cycle restoring divide (done at N+33), stalls via busy.
// Divider present only when MULDIV_DIV_EN is defined; otherwise divide ops complete at N+2 with result 0.
module ex_muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_MUL  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b11;
`ifdef MULDIV_DIV_EN
    localparam logic [1:0] S_DIV  = 2'b10;
`endif

    logic [1:0]  state_q, state_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] result_q, result_d;

    // MUL uses low word regardless of signedness; high-word ops extend per operand type.
    logic               a_sgn, b_sgn;
    logic signed [63:0] prod;
    logic [31:0]        mul_res;

    assign a_sgn   = (f3_q[1:0] != 2'b11) && a_q[31];
    assign b_sgn   = (f3_q[1:0] == 2'b01) && b_q[31];
    assign prod    = $signed({a_sgn, a_q}) * $signed({b_sgn, b_q});
    assign mul_res = (f3_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];

`ifdef MULDIV_DIV_EN
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [4:0]  cnt_q, cnt_d;

    logic        div_sgn, a_neg, b_neg, ge, div_fast;
    logic [31:0] b_mag, rem_nx, quo_nx, q_fix, r_fix, fast_res;
    logic [32:0] shift;

    assign div_sgn  = ~f3_q[0];
    assign a_neg    = div_sgn & a_q[31];
    assign b_neg    = div_sgn & b_q[31];
    assign b_mag    = b_neg ? -b_q : b_q;
    assign shift    = {rem_q, quo_q[31]};
    assign ge       = shift >= {1'b0, b_mag};
    assign rem_nx   = ge ? (shift[31:0] - b_mag) : shift[31:0];
    assign quo_nx   = {quo_q[30:0], ge};
    assign q_fix    = (a_neg ^ b_neg) ? -quo_nx : quo_nx;
    assign r_fix    = a_neg ? -rem_nx : rem_nx;
    // Divide-by-zero and signed overflow bypass the iteration entirely.
    assign div_fast = (b_q == 32'h0) ||
                      (div_sgn && a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF);
    assign fast_res = (b_q == 32'h0) ? (f3_q[1] ? a_q : 32'hFFFF_FFFF)
                                     : (f3_q[1] ? 32'h0 : 32'h8000_0000);
`endif

    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
`ifdef MULDIV_DIV_EN
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
`endif
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        f3_d = funct3;
                        a_d  = op_a;
                        b_d  = op_b;
`ifdef MULDIV_DIV_EN
                        if (funct3[2]) begin
                            state_d = S_DIV;
                            quo_d   = (~funct3[0] & op_a[31]) ? -op_a : op_a;
                            rem_d   = 32'h0;
                            cnt_d   = 5'd31;
                        end else begin
                            state_d = S_MUL;
                        end
`else
                        state_d = S_MUL;
`endif
                    end
                end
                S_MUL: begin
                    result_d = f3_q[2] ? 32'h0 : mul_res;
                    state_d  = S_DONE;
                end
`ifdef MULDIV_DIV_EN
                S_DIV: begin
                    if (div_fast) begin
                        result_d = fast_res;
                        state_d  = S_DONE;
                    end else begin
                        rem_d = rem_nx;
                        quo_d = quo_nx;
                        cnt_d = cnt_q - 5'd1;
                        if (cnt_q == 5'd0) begin
                            result_d = f3_q[1] ? r_fix : q_fix;
                            state_d  = S_DONE;
                        end
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            f3_q     <= 3'b0;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            result_q <= 32'h0;
`ifdef MULDIV_DIV_EN
            rem_q    <= 32'h0;
            quo_q    <= 32'h0;
            cnt_q    <= 5'd0;
`endif
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
`ifdef MULDIV_DIV_EN
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign busy   = (state_q == S_IDLE && start && !flush) || state_q == S_MUL
`ifdef MULDIV_DIV_EN
                    || state_q == S_DIV
`endif
                    ;
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif
    localparam int DIV_LAT = DIV_ON ? 33 : 2;
    localparam int FL_AT   = DIV_ON ? 10 : 1;
    localparam int RST_AT  = DIV_ON ? 5 : 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Issue one op at a falling edge (cycle N) and wait for done; lat is the cycle offset of done, -1 on timeout.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic busy1, output logic busy_d);
        @(negedge clk);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        #1;
        check("busy_at_N", {31'b0, busy}, 32'd1);
        lat    = -1;
        busy1  = 1'b0;
        busy_d = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (i == 1) begin
                busy1 = busy;
                start = 1'b0;
            end
            if (done) begin
                lat    = i;
                busy_d = busy;
                break;
            end
        end
    endtask

    int   lat;
    logic b1, bd;
    int   done_seen;

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b0;
        op_a   = 32'h0;
        op_b   = 32'h0;
        #1;
        check("rst_busy",   {31'b0, busy}, 32'd0);
        check("rst_done",   {31'b0, done}, 32'd0);
        check("rst_result", result, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, lat, b1, bd);
        check("mul_lat", lat, 32'd2);
        check("mul_res", result, 32'hFFFF_FFEB);
        check("mul_busy_N1", {31'b0, b1}, 32'd1);
        check("mul_busy_done", {31'b0, bd}, 32'd0);
        @(negedge clk);
        check("mul_done_pulse", {31'b0, done}, 32'd0);
        check("mul_res_held", result, 32'hFFFF_FFEB);

        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, b1, bd);
        check("mulhu_res", result, 32'hFFFF_FFFE);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, b1, bd);
        check("mulh_res", result, 32'h0);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, b1, bd);
        check("mulhsu_res", result, 32'hFFFF_FFFF);

        run_op(3'b100, 32'hFFFF_FFEC, 32'd3, lat, b1, bd);
        check("div_lat", lat, DIV_LAT);
        check("div_res", result, DIV_ON ? 32'hFFFF_FFFA : 32'h0);
        run_op(3'b110, 32'hFFFF_FFEC, 32'd3, lat, b1, bd);
        check("rem_res", result, DIV_ON ? 32'hFFFF_FFFE : 32'h0);
        run_op(3'b101, 32'd100, 32'd7, lat, b1, bd);
        check("divu_res", result, DIV_ON ? 32'd14 : 32'h0);

        run_op(3'b101, 32'd100, 32'd0, lat, b1, bd);
        check("divu0_lat", lat, 32'd2);
        check("divu0_res", result, DIV_ON ? 32'hFFFF_FFFF : 32'h0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, lat, b1, bd);
        check("removf_lat", lat, 32'd2);
        check("removf_res", result, 32'h0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, lat, b1, bd);
        check("divovf_res", result, DIV_ON ? 32'h8000_0000 : 32'h0);
        run_op(3'b111, 32'd7, 32'd0, lat, b1, bd);
        check("remu0_res", result, DIV_ON ? 32'd7 : 32'h0);

        // Abort an in-flight op with flush, then a fresh multiply.
        @(negedge clk);
        funct3    = DIV_ON ? 3'b101 : 3'b000;
        op_a      = 32'd100;
        op_b      = 32'd7;
        start     = 1'b1;
        done_seen = 0;
        for (int i = 1; i <= FL_AT + 1; i++) begin
            @(negedge clk);
            start = 1'b0;
            flush = (i == FL_AT);
            if (done) done_seen++;
        end
        #1;
        check("flush_idle_busy", {31'b0, busy}, 32'd0);
        check("flush_no_done", done_seen, 32'd0);
        check("flush_res_held", result, DIV_ON ? 32'd7 : 32'h0);
        run_op(3'b000, 32'd3, 32'd4, lat, b1, bd);
        check("post_flush_lat", lat, 32'd2);
        check("post_flush_res", result, 32'd12);

        // Async reset mid-op.
        @(negedge clk);
        funct3 = 3'b100;
        op_a   = 32'hFFFF_FFEC;
        op_b   = 32'd3;
        start  = 1'b1;
        for (int i = 1; i <= RST_AT; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_result", result, 32'h0);
        check("midrst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Start held high through DONE must not re-launch from DONE.
        @(negedge clk);
        funct3 = 3'b000;
        op_a   = 32'd5;
        op_b   = 32'd6;
        start  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("held_done", {31'b0, done}, 32'd1);
        check("held_busy_done", {31'b0, busy}, 32'd0);
        check("held_res", result, 32'd30);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("held_idle_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("held_no_second", {31'b0, done | busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
